// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver for the usart_rxd debug/control link.
// The line is synchronised and the start bit is validated at mid-bit. Each
// bit is then sampled at mid-bit, and the received byte is presented through
// a one-entry holding register with a valid/ready handshake.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, the frame is
// 8 data bits, 1 parity bit and a stop bit, and rx_parity_err is added.
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       usart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned FILL_W = 2;

  // Full bit period and half bit period, both expressed as down-counter
  // reload values (the sample is taken when the counter reaches zero).
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF   = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_d;
  logic                valid_d;
  logic                ferr_d;
  logic                ovr_d;
  logic                busy_d;
  logic                commit;
  logic                line;
  logic                fall;
  logic                cnt_zero;
`ifdef UART_RX_PARITY_EN
  logic                par_q, par_d;
  logic                perr_d;
`endif

  assign line     = sync2_q;
  assign cnt_zero = (cnt_q == '0);
  // Edge detection is armed only once all three input flops hold real line
  // samples. This keeps a line that is already low at reset release from
  // being seen as a start edge.
  assign fall     = (fill_q == FILL_W'(3)) && sync3_q && !sync2_q;

  // Input synchroniser and falling-edge history (idle-high reset values)
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= usart_rxd;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= S_IDLE;
      fill_q        <= '0;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rx_data       <= data_d;
      rx_valid      <= valid_d;
      rx_frame_err  <= ferr_d;
      rx_overrun    <= ovr_d;
      rx_busy       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      rx_parity_err <= perr_d;
`endif
    end
  end

  // Next-state, bit timing, shift register and holding-register logic
  always_comb begin
    state_d   = state_q;
    fill_d    = (fill_q == FILL_W'(3)) ? fill_q : fill_q + FILL_W'(1);
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = rx_data;
    valid_d   = rx_valid;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif

    // Consumer handshake; a same-cycle commit below takes precedence
    if (rx_valid && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d   = HALF;
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_zero) begin
          if (!line) begin
            cnt_d     = RELOAD;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_zero) begin
          shift_d = {line, shift_q[DATA_W-1:1]};
          cnt_d   = RELOAD;
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_zero) begin
          par_d   = line;
          cnt_d   = RELOAD;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (cnt_zero) begin
          if (line) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_BREAK: begin
        if (line) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Commit into the holding register; overwriting an unaccepted byte is an overrun
    if (commit) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_d   = rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      perr_d  = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed, scoreboard-based bench for uart_byte_rx.
// Bit period is 16 clocks. UART_RX_PARITY_EN adds the parity steps.
module tb_uart_byte_rx;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       usart_rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  int errors  = 0;
  int checks  = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_ovr   = 0;
  int n_perr  = 0;

  logic [7:0] sb[$];

  uart_byte_rx #(
    .CLKS_PER_BIT(BIT),
    .CNT_W       (16)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .usart_rxd    (usart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_busy      (rx_busy)
  );

  always #5 clk_in = ~clk_in;

  // One comparison: counted, asserted, and reported on mismatch
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock. The handshake seen by the coming rising edge is captured
  // first; the outputs are then sampled on the falling edge.
  task automatic step();
    logic       hs;
    logic [7:0] d;
    logic [7:0] e;
    hs = rx_valid && rx_ready;
    d  = rx_data;
    @(negedge clk_in);
    if (hs) begin
      if (sb.size() == 0) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_byte observed=0x%0h expected=none", d);
        end
      end else begin
        e = sb.pop_front();
        chk("rx_data_accepted", 32'(d), 32'(e));
      end
    end
    if (rx_valid)     n_valid++;
    if (rx_frame_err) n_ferr++;
    if (rx_overrun)   n_ovr++;
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) n_perr++;
`endif
  endtask

  task automatic hold(input logic v, input int n);
    usart_rxd = v;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    if (PAR_EN) hold(par, BIT);
    hold(stop, BIT);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_frame(b, ^b, stop);
  endtask

  initial begin
    int v0;
    int f0;
    int o0;
    int p0;

    rst_n_in  = 1'b0;
    usart_rxd = 1'b1;
    rx_ready  = 1'b1;
    repeat (3) step();
    chk("reset_rx_data",  32'(rx_data),      32'h00);
    chk("reset_rx_valid", 32'(rx_valid),     32'h0);
    chk("reset_rx_busy",  32'(rx_busy),      32'h0);
    chk("reset_ferr",     32'(rx_frame_err), 32'h0);
    chk("reset_overrun",  32'(rx_overrun),   32'h0);
    rst_n_in = 1'b1;
    hold(1'b1, 8);

    // Single byte with ready high: one-cycle valid, no error pulses
    v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    hold(1'b1, 8);
    chk("a5_valid_cycles", 32'(n_valid - v0), 32'd1);
    chk("a5_ferr",         32'(n_ferr - f0),  32'd0);
    chk("a5_overrun",      32'(n_ovr - o0),   32'd0);
    chk("a5_sb_empty",     32'(sb.size()),    32'd0);

    // Short low glitch on the idle line is rejected as a false start
    v0 = n_valid; f0 = n_ferr;
    hold(1'b0, 4);
    hold(1'b1, 12);
    chk("glitch_busy",  32'(rx_busy),         32'h0);
    chk("glitch_valid", 32'(n_valid - v0),    32'd0);
    chk("glitch_ferr",  32'(n_ferr - f0),     32'd0);

    // Stop bit low, then line held low: one frame error and no extra frames
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h5A, ^(8'h5A), 1'b0);
    hold(1'b0, 40);
    chk("break_busy",  32'(rx_busy),      32'h1);
    chk("break_ferr",  32'(n_ferr - f0),  32'd1);
    chk("break_valid", 32'(n_valid - v0), 32'd0);
    hold(1'b1, 6);
    chk("break_exit_busy", 32'(rx_busy),  32'h0);
    chk("break_ferr_total", 32'(n_ferr - f0), 32'd1);

    // Overrun: two bytes with ready low, the second overwrites the first
    rx_ready = 1'b0;
    o0 = n_ovr;
    send_byte(8'h11, 1'b1);
    send_byte(8'h3C, 1'b1);
    hold(1'b1, 4);
    chk("ovr_pulses",   32'(n_ovr - o0), 32'd1);
    chk("ovr_rx_data",  32'(rx_data),    32'h3C);
    chk("ovr_rx_valid", 32'(rx_valid),   32'h1);
    sb.push_back(8'h3C);
    rx_ready = 1'b1;
    step();
    chk("ovr_valid_cleared", 32'(rx_valid),   32'h0);
    chk("ovr_sb_empty",      32'(sb.size()),  32'd0);

    // Reset in the middle of bit 3 of 0xFF, then a clean 0x81
    v0 = n_valid;
    hold(1'b0, BIT);
    hold(1'b1, 3 * BIT + BIT / 2);
    rst_n_in = 1'b0;
    step();
    chk("midrst_busy",    32'(rx_busy),  32'h0);
    chk("midrst_rx_data", 32'(rx_data),  32'h00);
    chk("midrst_valid",   32'(rx_valid), 32'h0);
    rst_n_in = 1'b1;
    hold(1'b1, 6 * BIT);
    sb.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    hold(1'b1, 8);
    chk("midrst_valid_cycles", 32'(n_valid - v0), 32'd1);
    chk("midrst_sb_empty",     32'(sb.size()),    32'd0);

    // Line already low at reset release is not a start edge
    v0 = n_valid;
    usart_rxd = 1'b0;
    step();
    rst_n_in = 1'b0;
    step();
    step();
    rst_n_in = 1'b1;
    hold(1'b0, 3 * BIT);
    chk("lowrst_busy",  32'(rx_busy),      32'h0);
    hold(1'b1, 8);
    chk("lowrst_busy_after_rise", 32'(rx_busy), 32'h0);
    chk("lowrst_valid", 32'(n_valid - v0), 32'd0);

    // Back-to-back frames with no idle gap
    v0 = n_valid;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    hold(1'b1, 8);
    chk("b2b_valid_cycles", 32'(n_valid - v0), 32'd2);
    chk("b2b_sb_empty",     32'(sb.size()),    32'd0);

    // Even parity: 0x07 needs parity bit 1
    if (PAR_EN) begin
      p0 = n_perr;
      sb.push_back(8'h07);
      send_frame(8'h07, 1'b0, 1'b1);
      hold(1'b1, 8);
      chk("par_bad_pulse", 32'(n_perr - p0), 32'd1);
      p0 = n_perr;
      sb.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      hold(1'b1, 8);
      chk("par_good_pulse", 32'(n_perr - p0), 32'd0);
      chk("par_sb_empty",   32'(sb.size()),   32'd0);
    end

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial-to-parallel UART receiver for the board's `usart_rxd` pin, the receive end of the host debug/control link whose transmit side drives `usart_txd`. It synchronises the asynchronous line, validates start bits, samples 8N1 frames at mid-bit and presents each byte through a one-entry holding register with a valid/ready handshake. It sits under `dsi_host_top`, feeding the register/command logic.

## Interface
- `CLKS_PER_BIT`, 868, `clk_in` cycles per bit period (100 MHz / 115200); legal range 4..65535.
- `CNT_W`, 16, width of the bit-period counter; must hold `CLKS_PER_BIT-1`.

- `clk_in` input 1 — sole clock; all logic on rising edge.
- `rst_n_in` input 1 — reset, asynchronous, active-low.
- `usart_rxd` input 1 — asynchronous serial line, idle high.
- `rx_data` output 8 — received byte, stable while `rx_valid`=1.
- `rx_valid` output 1 — holding register full.
- `rx_ready` input 1 — consumer accepts byte when `rx_valid && rx_ready`.
- `rx_frame_err` output 1 — one-cycle pulse: stop bit sampled low.
- `rx_overrun` output 1 — one-cycle pulse: byte completed while holding register full and not being accepted.
- `rx_busy` output 1 — high in any state other than IDLE.

## Operation
- Input path: 2-flop synchroniser on `usart_rxd` (both flops reset to 1), then a third flop for falling-edge detection.
- FSM states: IDLE, START, DATA, STOP, BREAK (plus PARITY, see Configuration).
- IDLE: on synchronised falling edge, load counter, go START.
- START: after `CLKS_PER_BIT/2` (integer floor) cycles sample line; 0 → DATA, counter reloads; 1 → false start, back to IDLE, no flags.
- DATA: every `CLKS_PER_BIT` cycles sample one bit into a shift register, LSB first; after the 8th sample go STOP.
- STOP: after `CLKS_PER_BIT` cycles sample; 1 → commit byte, go IDLE; 0 → pulse `rx_frame_err`, discard byte, go BREAK.
- BREAK: wait for synchronised line = 1, then IDLE (prevents a held-low line producing repeated frames).
- Commit: holding register loads the shift register, `rx_valid` set.
- Handshake: `rx_valid` clears the cycle after `rx_valid && rx_ready`. Commit in the same cycle as acceptance: no overrun, new byte loaded, `rx_valid` stays 1.
- Overrun: commit while `rx_valid=1` and `rx_ready=0` → new byte overwrites `rx_data`, `rx_overrun` pulses, `rx_valid` stays 1.
- Counter: down-counter of width `CNT_W`, reload `CLKS_PER_BIT-1`, sample on zero; no wrap beyond reload.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0, `rx_busy`=0, FSM=IDLE.
- Pin-to-edge-detect latency: 3 cycles.
- Stop-bit sample to `rx_valid`=1 (and to `rx_frame_err` / `rx_overrun` pulse): 1 cycle, registered outputs.
- Reset asserted mid-frame: all state returns to reset values immediately; after release receiver waits in IDLE for the next falling edge (a line already low is ignored until it rises and falls again).
- Back-to-back frames: next start edge accepted in the cycle IDLE is re-entered; tolerates ±4% baud mismatch at `CLKS_PER_BIT`≥16.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8 data + 1 parity + stop; PARITY state sampled one bit period after bit 7; parameter `PARITY_ODD` (default 0 = even) selects sense; added output `rx_parity_err` (1-cycle pulse, reset 0) asserts alongside commit when parity mismatches; byte still committed.
- Not defined: 8N1 only, no PARITY state, no `rx_parity_err` port.

## Test plan
- `CLKS_PER_BIT`=16, send 0xA5 8N1, `rx_ready`=1 → `rx_valid` one-cycle pulse with `rx_data`=0xA5, no error pulses.
- 4-cycle low glitch on idle line → no `rx_valid`, no `rx_frame_err`, FSM back in IDLE within 12 cycles.
- Send 0x5A with stop bit forced 0, then hold line low 40 cycles → one `rx_frame_err` pulse, no `rx_valid`, no further frames until line high.
- `rx_ready`=0, send 0x11 then 0x3C → `rx_overrun` pulses once, `rx_data`=0x3C, `rx_valid`=1; raise `rx_ready` → `rx_valid`=0 next cycle.
- Assert `rst_n_in` low during bit 3 of 0xFF, release, send 0x81 → only 0x81 received.
- With `UART_RX_PARITY_EN`, even parity, send 0x07 with parity bit 0 → `rx_data`=0x07 and `rx_parity_err` pulse; with parity bit 1 → no pulse.
